// File: rtl/adder_ctrl_pkg.sv
// Shared control definitions for the adder arbiter slice.
//   ADDER_BITS : default operand width of the shared adder
//   state_t    : arbiter FSM encoding (IDLE / COMPUTE / RESP)
package adder_ctrl_pkg;

    localparam int ADDER_BITS = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        RESP    = 2'd2
    } state_t;

endpackage

// File: rtl/n_ripple_carry_adder.sv
// BITS-bit ripple-carry adder.
// Ports:
//   ops : packed operands {ci, a, b}; ci is the MSB, b occupies the low BITS bits
//   sum : BITS+1 result {carry_out, sum}
module n_ripple_carry_adder
    import adder_ctrl_pkg::*;
#(
    parameter int BITS = ADDER_BITS
) (
    input  logic [2*BITS:0] ops,
    output logic [BITS:0]   sum
);

    always_comb begin
        logic c;
        sum = '0;
        c   = ops[2*BITS];
        for (int i = 0; i < BITS; i++) begin
            sum[i] = ops[BITS+i] ^ ops[i] ^ c;
            c      = (ops[BITS+i] & ops[i]) | (c & (ops[BITS+i] ^ ops[i]));
        end
        sum[BITS] = c;
    end

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one ripple-carry adder between two requesters.
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   reqN_valid / reqN_ready     : request handshake per requester (ready is combinational)
//   reqN_a, reqN_b, reqN_ci     : operands and carry-in per requester
//   rsp_valid / rsp_ready       : response handshake
//   rsp_id                      : requester that issued the result
//   rsp_sum                     : registered {carry_out, sum}
module adder_arbiter
    import adder_ctrl_pkg::*;
#(
    parameter int BITS = ADDER_BITS
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [BITS-1:0] req0_a,
    input  logic [BITS-1:0] req0_b,
    input  logic            req0_ci,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [BITS-1:0] req1_a,
    input  logic [BITS-1:0] req1_b,
    input  logic            req1_ci,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_id,
    output logic [BITS:0]   rsp_sum
);

    state_t          state;
    logic            last_grant;
    logic            cur_id;
    logic            pick1;
    logic            accept;
    logic [BITS-1:0] a_p0;
    logic [BITS-1:0] b_p0;
    logic            ci_p0;
    logic [BITS:0]   sum_p0;

    // Requester 1 wins when it is the only one valid, or on a tie when
    // requester 0 was granted last.
    always_comb begin
        pick1      = req1_valid && (!req0_valid || !last_grant);
        accept     = (state == IDLE) && !rst && (req0_valid || req1_valid);
        req0_ready = accept && !pick1;
        req1_ready = accept && pick1;
    end

    // Stage p0: operands of the granted requester, held for the adder
    always_ff @(posedge clk) begin
        if (accept) begin
            a_p0  <= pick1 ? req1_a  : req0_a;
            b_p0  <= pick1 ? req1_b  : req0_b;
            ci_p0 <= pick1 ? req1_ci : req0_ci;
        end
    end

    n_ripple_carry_adder #(
        .BITS (BITS)
    ) u_adder (
        .ops ({ci_p0, a_p0, b_p0}),
        .sum (sum_p0)
    );

    // Reset clears the response as well, so an operation in flight is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            cur_id     <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_sum    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cur_id     <= pick1;
                        last_grant <= pick1;
                        state      <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    rsp_sum   <= sum_p0;
                    rsp_id    <= cur_id;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter (BITS = 4).
module tb_adder_arbiter;

    localparam int BITS = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            req0_valid, req1_valid;
    logic            req0_ready, req1_ready;
    logic [BITS-1:0] req0_a, req0_b, req1_a, req1_b;
    logic            req0_ci, req1_ci;
    logic            rsp_valid, rsp_ready, rsp_id;
    logic [BITS:0]   rsp_sum;

    int checks   = 0;
    int failures = 0;
    int acc0, acc1;

    always #5 clk = ~clk;

    adder_arbiter #(.BITS(BITS)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ci    (req0_ci),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ci    (req1_ci),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_sum    (rsp_sum)
    );

    // Inputs change just after the rising edge; outputs are read at the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b0;
        req0_a = 4'd5; req0_b = 4'd6; req0_ci = 1'b1;
        req1_a = 4'd2; req1_b = 4'd3; req1_ci = 1'b0;
        tick(); tick(); settle();
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        checks++; if (rsp_sum !== 5'd0) begin failures++; $display("FAIL reset_rsp_sum got %0d want 0", rsp_sum); end
        checks++; if (rsp_id !== 1'b0) begin failures++; $display("FAIL reset_rsp_id got %b want 0", rsp_id); end
        checks++; if ({req1_ready, req0_ready} !== 2'b00) begin failures++; $display("FAIL reset_readies got %b want 00", {req1_ready, req0_ready}); end
        tick();
        rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic test_single();
        req0_a = 4'd9; req0_b = 4'd8; req0_ci = 1'b1; req0_valid = 1'b1; rsp_ready = 1'b1;
        settle();
        checks++; if ({req1_ready, req0_ready} !== 2'b01) begin failures++; $display("FAIL single_accept got %b want 01", {req1_ready, req0_ready}); end
        tick(); req0_valid = 1'b0; settle();
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL single_early_valid got %b want 0", rsp_valid); end
        tick(); settle();
        checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL single_latency got %b want 1", rsp_valid); end
        checks++; if (rsp_sum !== 5'b10010) begin failures++; $display("FAIL single_sum got %0d want 18", rsp_sum); end
        checks++; if (rsp_id !== 1'b0) begin failures++; $display("FAIL single_id got %b want 0", rsp_id); end
        tick(); settle();
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL single_release got %b want 0", rsp_valid); end
        tick();
    endtask

    task automatic test_tie();
        logic [1:0] exp_grant;
        logic [4:0] exp_sum;
        rst = 1'b1; rsp_ready = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        rst = 1'b0;
        req0_a = 4'd3; req0_b = 4'd4; req0_ci = 1'b0;
        req1_a = 4'd7; req1_b = 4'd1; req1_ci = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exp_grant = (k % 2 == 0) ? 2'b01 : 2'b10;
            exp_sum   = (k % 2 == 0) ? 5'd7 : 5'd8;
            settle();
            checks++; if ({req1_ready, req0_ready} !== exp_grant) begin failures++; $display("FAIL tie_grant%0d got %b want %b", k, {req1_ready, req0_ready}, exp_grant); end
            tick(); settle();
            checks++; if ({req1_ready, req0_ready} !== 2'b00) begin failures++; $display("FAIL tie_busy_ready%0d got %b want 00", k, {req1_ready, req0_ready}); end
            tick(); settle();
            checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL tie_valid%0d got %b want 1", k, rsp_valid); end
            checks++; if (rsp_sum !== exp_sum) begin failures++; $display("FAIL tie_sum%0d got %0d want %0d", k, rsp_sum, exp_sum); end
            checks++; if (rsp_id !== exp_grant[1]) begin failures++; $display("FAIL tie_id%0d got %b want %b", k, rsp_id, exp_grant[1]); end
            if (k == 2) begin
                req0_valid = 1'b0; req1_valid = 1'b0;
            end
            tick();
        end
    endtask

    task automatic test_back_pressure();
        // Requester 0 was granted last, so requester 1 wins this tie.
        req0_a = 4'd2; req0_b = 4'd3; req0_ci = 1'b0;
        req1_a = 4'd4; req1_b = 4'd4; req1_ci = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b0;
        settle();
        checks++; if ({req1_ready, req0_ready} !== 2'b10) begin failures++; $display("FAIL bp_grant got %b want 10", {req1_ready, req0_ready}); end
        tick(); tick(); settle();
        checks++; if (rsp_valid !== 1'b1 || rsp_sum !== 5'd9 || rsp_id !== 1'b1) begin
            failures++; $display("FAIL bp_first_rsp got v=%b s=%0d id=%b want v=1 s=9 id=1", rsp_valid, rsp_sum, rsp_id);
        end
        for (int i = 0; i < 5; i++) begin
            tick(); settle();
            checks++; if (rsp_valid !== 1'b1 || rsp_sum !== 5'd9 || rsp_id !== 1'b1) begin
                failures++; $display("FAIL bp_hold%0d got v=%b s=%0d id=%b want v=1 s=9 id=1", i, rsp_valid, rsp_sum, rsp_id);
            end
            checks++; if ({req1_ready, req0_ready} !== 2'b00) begin failures++; $display("FAIL bp_ready%0d got %b want 00", i, {req1_ready, req0_ready}); end
        end
        tick(); rsp_ready = 1'b1; settle();
        checks++; if (rsp_valid !== 1'b1 || {req1_ready, req0_ready} !== 2'b00) begin
            failures++; $display("FAIL bp_complete got v=%b rdy=%b want v=1 rdy=00", rsp_valid, {req1_ready, req0_ready});
        end
        tick(); settle();
        checks++; if ({req1_ready, req0_ready} !== 2'b01) begin failures++; $display("FAIL bp_next_grant got %b want 01", {req1_ready, req0_ready}); end
        tick(); req0_valid = 1'b0; req1_valid = 1'b0;
        tick(); tick();
    endtask

    task automatic test_max_operands();
        logic [3:0] va [2];
        logic [3:0] vb [2];
        logic       vc [2];
        logic [4:0] vs [2];
        va[0] = 4'd15; vb[0] = 4'd15; vc[0] = 1'b1; vs[0] = 5'd31;
        va[1] = 4'd0;  vb[1] = 4'd0;  vc[1] = 1'b0; vs[1] = 5'd0;
        rsp_ready = 1'b1;
        for (int v = 0; v < 2; v++) begin
            req0_a = va[v]; req0_b = vb[v]; req0_ci = vc[v]; req0_valid = 1'b1;
            settle();
            checks++; if ({req1_ready, req0_ready} !== 2'b01) begin failures++; $display("FAIL max_grant%0d got %b want 01", v, {req1_ready, req0_ready}); end
            tick(); req0_valid = 1'b0;
            tick(); settle();
            checks++; if (rsp_valid !== 1'b1 || rsp_sum !== vs[v] || rsp_id !== 1'b0) begin
                failures++; $display("FAIL max_sum%0d got v=%b s=%0d id=%b want v=1 s=%0d id=0", v, rsp_valid, rsp_sum, rsp_id, vs[v]);
            end
            tick();
        end
    endtask

    task automatic test_reset_compute();
        // Requester 0 was granted last, so requester 1 is accepted and then dropped.
        req0_a = 4'd1; req0_b = 4'd2; req0_ci = 1'b0;
        req1_a = 4'd5; req1_b = 4'd6; req1_ci = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
        settle();
        checks++; if ({req1_ready, req0_ready} !== 2'b10) begin failures++; $display("FAIL rstc_grant got %b want 10", {req1_ready, req0_ready}); end
        tick(); rst = 1'b1; settle();
        checks++; if ({req1_ready, req0_ready} !== 2'b00) begin failures++; $display("FAIL rstc_ready_in_rst got %b want 00", {req1_ready, req0_ready}); end
        tick(); rst = 1'b0; settle();
        checks++; if (rsp_valid !== 1'b0 || rsp_sum !== 5'd0 || rsp_id !== 1'b0) begin
            failures++; $display("FAIL rstc_cleared got v=%b s=%0d id=%b want v=0 s=0 id=0", rsp_valid, rsp_sum, rsp_id);
        end
        checks++; if ({req1_ready, req0_ready} !== 2'b01) begin failures++; $display("FAIL rstc_tie_after got %b want 01", {req1_ready, req0_ready}); end
        tick(); req0_valid = 1'b0; req1_valid = 1'b0; settle();
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rstc_no_stale got %b want 0", rsp_valid); end
        tick(); settle();
        checks++; if (rsp_valid !== 1'b1 || rsp_sum !== 5'd3 || rsp_id !== 1'b0) begin
            failures++; $display("FAIL rstc_new_rsp got v=%b s=%0d id=%b want v=1 s=3 id=0", rsp_valid, rsp_sum, rsp_id);
        end
        tick();
    endtask

    // Transaction-level reference: requesters hold a pending operation until
    // granted; at most one operation is outstanding; its result appears two
    // cycles after the grant and stays until taken; ties go to the requester
    // that was not granted last.
    task automatic test_traffic(input string nm, input int ncyc, input int p0, input int p1,
                                input int prdy, output int n0, output int n1);
        bit         pend [2];
        logic [3:0] pa [2];
        logic [3:0] pb [2];
        logic       pci [2];
        int         pct [2];
        int         last, age, w;
        bit         outst, exp_valid;
        logic [4:0] esum;
        logic       eid;
        logic [1:0] exp_rdy;
        pct[0] = p0; pct[1] = p1;
        pend[0] = 0; pend[1] = 0;
        last = 1; outst = 0; age = 0; esum = '0; eid = 1'b0;
        n0 = 0; n1 = 0;
        rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        for (int cyc = 0; cyc < ncyc + 40; cyc++) begin
            tick();
            if (outst) age++;
            for (int r = 0; r < 2; r++) begin
                if (!pend[r] && cyc < ncyc && $urandom_range(99) < pct[r]) begin
                    pend[r] = 1;
                    pa[r] = 4'($urandom); pb[r] = 4'($urandom); pci[r] = 1'($urandom);
                end
            end
            req0_valid = pend[0];
            req1_valid = pend[1];
            req0_a  = pend[0] ? pa[0]  : 4'($urandom);
            req0_b  = pend[0] ? pb[0]  : 4'($urandom);
            req0_ci = pend[0] ? pci[0] : 1'($urandom);
            req1_a  = pend[1] ? pa[1]  : 4'($urandom);
            req1_b  = pend[1] ? pb[1]  : 4'($urandom);
            req1_ci = pend[1] ? pci[1] : 1'($urandom);
            rsp_ready = (cyc >= ncyc) ? 1'b1 : ($urandom_range(99) < prdy);
            settle();
            w = -1;
            exp_rdy = 2'b00;
            if (!outst && (pend[0] || pend[1])) begin
                w = (pend[0] && pend[1]) ? 1 - last : (pend[0] ? 0 : 1);
                exp_rdy[w] = 1'b1;
            end
            checks++; if ({req1_ready, req0_ready} !== exp_rdy) begin
                failures++; $display("FAIL %s_ready cyc%0d got %b want %b", nm, cyc, {req1_ready, req0_ready}, exp_rdy);
            end
            exp_valid = outst && (age >= 2);
            checks++; if (rsp_valid !== exp_valid) begin
                failures++; $display("FAIL %s_valid cyc%0d got %b want %b", nm, cyc, rsp_valid, exp_valid);
            end
            if (exp_valid) begin
                checks++; if (rsp_sum !== esum || rsp_id !== eid) begin
                    failures++; $display("FAIL %s_result cyc%0d got s=%0d id=%b want s=%0d id=%b", nm, cyc, rsp_sum, rsp_id, esum, eid);
                end
                if (rsp_ready) outst = 0;
            end
            if (w >= 0) begin
                outst = 1; age = 0;
                esum = {1'b0, pa[w]} + {1'b0, pb[w]} + {4'b0, pci[w]};
                eid  = 1'(w);
                last = w;
                pend[w] = 0;
                if (cyc < ncyc) begin
                    if (w == 0) n0++; else n1++;
                end
            end
        end
        checks++; if (outst || pend[0] || pend[1]) begin
            failures++; $display("FAIL %s_drain got outstanding=%b pending=%b%b want 0 00", nm, outst, pend[1], pend[0]);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic test_streaming();
        test_traffic("stream", 30, 0, 100, 100, acc0, acc1);
        checks++; if (acc1 != 10) begin failures++; $display("FAIL stream_r1_accepts got %0d want 10", acc1); end
        checks++; if (acc0 != 0) begin failures++; $display("FAIL stream_r0_accepts got %0d want 0", acc0); end
    endtask

    task automatic test_random();
        test_traffic("random", 400, 55, 65, 70, acc0, acc1);
        checks++; if (acc0 == 0 || acc1 == 0) begin
            failures++; $display("FAIL random_both_served got r0=%0d r1=%0d want both nonzero", acc0, acc1);
        end
    endtask

    initial begin
        rst = 1'b1; rsp_ready = 1'b0;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_ci = 1'b0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_ci = 1'b0;
        test_reset();
        test_single();
        test_tie();
        test_back_pressure();
        test_max_operands();
        test_reset_compute();
        test_streaming();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Shares one `BITS`-bit ripple-carry adder between two requesters using round-robin arbitration.
- Each requester presents an operand pair and carry-in on a valid/ready handshake.
- The block latches the winning operands and drives the shared adder.
- It returns the registered `BITS+1`-bit sum, tagged with the requester ID, on a single valid/ready response channel.

It sits between the operand-producing logic (switch capture / upstream controllers) and the result consumers (LED/display path).

## Interface
Parameters:
- `BITS`, 4: operand width; the sum is `BITS+1` bits.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req0_valid`  in  1  requester 0 has an operation pending.
- `req0_ready`  out  1  requester 0 operation accepted this cycle.
- `req0_a`, `req0_b`  in  BITS each  requester 0 operands.
- `req0_ci`  in  1  requester 0 carry-in.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_ci`: same as requester 0, for requester 1.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer takes result.
- `rsp_id`  out  1  requester that issued the result.
- `rsp_sum`  out  BITS+1  `{carry_out, sum}`.

## Operation
- FSM states: IDLE, COMPUTE, RESP.
- **IDLE**
  - If no valid: stay in IDLE.
  - Else pick the winner. If only one is valid, it wins. If both are valid, the requester not named by `last_grant` wins.
  - Assert the winner's `reqX_ready` combinationally in the same cycle. The other ready stays 0.
  - At the edge: latch `a`, `b`, `ci`; set `cur_id`; set `last_grant <= winner`; go to COMPUTE.
- **COMPUTE**
  - The latched operands drive the shared adder.
  - At the edge: `rsp_sum <= adder output`, `rsp_id <= cur_id`, `rsp_valid <= 1`; go to RESP.
- **RESP**
  - Hold `rsp_valid`, `rsp_sum` and `rsp_id` stable.
  - When `rsp_ready == 1`: at the edge set `rsp_valid <= 0` and go to IDLE.
- Both `reqX_ready` are 0 in COMPUTE and RESP. Requests are never accepted while an operation is outstanding.
- Handshake rule: a requester holds valid and operands stable until its ready is seen. Dropping valid early is a protocol violation; the block does not track it.
- Arithmetic: `rsp_sum = a + b + ci`, unsigned, `BITS+1` wide, with no truncation.
  - Maximum is `2^(BITS+1) - 1`; for `BITS = 4`: 15 + 15 + 1 = 31.
- Fairness: when both requesters stay valid, grants alternate strictly (0, 1, 0, 1, …). Neither requester waits more than one other operation.

## Timing
- Reset values:
  - state = IDLE
  - `rsp_valid = 0`, `rsp_sum = 0`, `rsp_id = 0`
  - `last_grant = 1`, so requester 0 wins the first tie
  - `req0_ready = req1_ready = 0` (combinational readies are 0 while `rst` is high)
- Latency: accept at cycle t (ready high), `rsp_valid` high at cycle t+2.
- Throughput: one operation per 3 cycles when `rsp_ready` is tied high. The next accept is at t+3.
- Reset mid-operation (COMPUTE or RESP): the operation is discarded; no response is ever produced. The next cycle shows reset values.
- Simultaneous `rsp_ready` and new requests in RESP: the response completes; arbitration happens in the following IDLE cycle.

## Structure
- Shared package `adder_ctrl_pkg` holds:
  - state encoding constants: IDLE = 2'd0, COMPUTE = 2'd1, RESP = 2'd2
  - default width constant `ADDER_BITS = 4`
- One sub-module: the team's existing `BITS`-bit ripple-carry adder `n_ripple_carry_adder`, instantiated once.
  - Its input vector is packed as `{ci, a, b}`.
  - Its output is the `BITS+1` sum.
- The arbiter logic, FSM and response register live in `adder_arbiter`.

## Test plan
All scenarios use `BITS = 4`.
- Single request: `req0` with a=9, b=8, ci=1, `rsp_ready` high → `req0_ready` at cycle 0; `rsp_valid` at cycle 2 with `rsp_sum = 18` (5'b10010) and `rsp_id = 0`.
- Tie after reset: both valid and held (r0: 3+4, r1: 7+1) → r0 served first (sum 7, id 0), then r1 (sum 8, id 1). A third tie grants r0 again.
- Back-pressure: `rsp_ready` low for 5 cycles in RESP → `rsp_valid`, `rsp_sum` and `rsp_id` stable. Both readies stay 0 even with both valid.
- Maximum operands: a=15, b=15, ci=1 → `rsp_sum = 31`. Also a=0, b=0, ci=0 → `rsp_sum = 0`.
- Reset in COMPUTE: `rst` pulsed one cycle → no `rsp_valid` ever appears for that operation. The next tie is granted to r0.
- Streaming: r1 continuously valid, r0 idle → r1 accepted every 3 cycles, each result tagged `rsp_id = 1`, with no starvation.
